// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 peripheral (CPOL=0, CPHA=0), far end of the SPI master.
//
// All SPI pins are oversampled on raw_clk through SYNC_STAGES synchroniser flops
// plus one edge-detect flop. Bytes are shifted MSB first. A one-entry holding
// register supplies the reply byte. IDLE_BYTE is sent when the holding register
// is empty at a byte boundary.
//
// Ports
//   raw_clk      system clock (only clock)
//   reset        synchronous, active-high reset
//   cs_n         SPI chip select, active low (async)
//   sclk         SPI clock, idles low (async)
//   mosi         SPI data in (async)
//   miso         SPI data out, registered
//   tx_data      next reply byte
//   tx_load      write tx_data into the holding register
//   tx_ready     holding register empty
//   rx_data      last complete received byte
//   rx_valid     one-cycle strobe, rx_data updated
//   tx_underrun  one-cycle strobe, IDLE_BYTE substituted for an empty holding register
//   active       transfer in progress (state SHIFT)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | chip select not asserted; sclk events ignored, miso held 0
// S_SHIFT | chip select asserted; shift on sclk rise/fall events

module spi_peripheral #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       active
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;
    logic                   armed_q;

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall_ev, cs_rise_ev, sclk_rise_ev, sclk_fall_ev;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The chain resets to "cs high", so a cs_n held low across reset release
    // would otherwise ripple through as a fall. armed_q only sets once the
    // chain has been refilled with real pin samples and shows cs high.
    assign cs_fall_ev   = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise_ev   = ~cs_prev_q & cs_s;
    assign sclk_rise_ev = ~sclk_prev_q & sclk_s;
    assign sclk_fall_ev = sclk_prev_q & ~sclk_s;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            armed_q     <= armed_q | (cs_s & fill_q[SYNC_STAGES-1]);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cs_fall_ev) state_d = S_SHIFT;
            S_SHIFT: if (cs_rise_ev) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active = (state_q == S_SHIFT);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Bit 7 of a loaded byte goes straight to miso, so only bits 6:0 are kept.
    logic [6:0] tx_shift_q, tx_shift_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic       miso_q, miso_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       reload;
    logic       consume;

    always_comb begin
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        reload      = 1'b0;
        consume     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cs_fall_ev) begin
                    reload      = 1'b1;
                    bit_cnt_d   = 3'd0;
                    byte_done_d = 1'b0;
                end
            end
            S_SHIFT: begin
                // cs rise takes priority; a coincident sclk event is dropped.
                if (cs_rise_ev) begin
                    bit_cnt_d   = 3'd0;
                    byte_done_d = 1'b0;
                    miso_d      = 1'b0;
                end else if (sclk_rise_ev) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d   = {rx_shift_q, mosi_s};
                        rx_valid_d  = 1'b1;
                        byte_done_d = 1'b1;
                    end
                end else if (sclk_fall_ev) begin
                    if (byte_done_q) begin
                        reload      = 1'b1;
                        byte_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[5:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end
                end
            end
            default: ;
        endcase

        if (reload) begin
            if (hold_full_q) begin
                tx_shift_d = hold_q[6:0];
                miso_d     = hold_q[7];
                consume    = 1'b1;
            end else begin
                tx_shift_d = IDLE_BYTE[6:0];
                miso_d     = IDLE_BYTE[7];
                underrun_d = 1'b1;
            end
        end

        if (consume) begin
            hold_full_d = 1'b0;
        end
        // A load on the consume cycle refills the slot the reload just freed.
        if (tx_load && (!hold_full_q || consume)) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign miso        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign tx_ready    = ~hold_full_q;

endmodule
